// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the sequence-detector family stimulus source.
//   - state_e     : FSM state encoding of seq_pattern_generator (IDLE/SHIFT/GAP)
//   - MAX_LEN_DEF : default maximum pattern length in bits
//   - REP_W       : width of the repeat counter / pat_rep port
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int REP_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_expect_model.sv
// ----------------------------------------------------------------------------
// seq_expect_model
//   Reference Moore 01/10 detector on the emitted serial stream. y_exp goes
//   high for one cycle after any valid bit that differs from the valid bit
//   directly before it. A cycle with x_valid=0 wipes the history, so gaps and
//   pattern boundaries never form a sequence.
//   Only instantiated when SEQ_PATTERN_GENERATOR_EXPECT_EN is defined.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   x        in   serial bit
//   x_valid  in   x carries a pattern bit this cycle
//   y_exp    out  registered expected detector output
// ----------------------------------------------------------------------------
module seq_expect_model
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic x_valid,
    output logic y_exp
);

    logic prev_bit;
    logic prev_ok;   // prev_bit holds a valid bit from the cycle before

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bit <= 1'b0;
            prev_ok  <= 1'b0;
            y_exp    <= 1'b0;
        end else if (x_valid) begin
            y_exp    <= prev_ok && (x != prev_bit);
            prev_bit <= x;
            prev_ok  <= 1'b1;
        end else begin
            y_exp    <= 1'b0;
            prev_ok  <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_pattern_generator.sv
// ----------------------------------------------------------------------------
// seq_pattern_generator
//   Serial stimulus source: takes a parallel pattern through a valid/ready
//   handshake and shifts it out LSB first, one bit per clock, on x. The
//   pattern is sent pat_rep+1 times, with GAP_CYCLES idle cycles between
//   repeats (0 = back-to-back).
//
//   Handshake: a transfer happens on a rising edge where pat_valid and
//   pat_ready are both 1. pat_ready is combinational (state==IDLE); the
//   source must hold pat_valid and the pattern fields stable until then.
//   pat_valid while busy has no effect.
//
// Parameters:
//   MAX_LEN     maximum pattern length in bits
//   LEN_W       width of pat_len, must hold MAX_LEN
//   GAP_CYCLES  idle cycles between repeats
//   IDLE_LEVEL  value on x when no pattern bit is being driven
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   pat_valid  in   pattern offer
//   pat_ready  out  generator can accept a pattern (state==IDLE)
//   pat_data   in   pattern bits, sent LSB first
//   pat_len    in   bits to send, legal 1..MAX_LEN
//   pat_rep    in   extra repeats
//   x          out  registered serial bit
//   x_valid    out  x carries a pattern bit this cycle
//   busy       out  state != IDLE
//   done       out  one-cycle pulse after the last bit of the last repeat
//   err        out  one-cycle pulse on an accepted illegal pat_len
//   dbg_state  out  current FSM state, for checkers
//   y_exp      out  expected Moore 01/10 detector output
//                   (only with SEQ_PATTERN_GENERATOR_EXPECT_EN defined)
// ----------------------------------------------------------------------------
module seq_pattern_generator
    import seq_pkg::*;
#(
    parameter int   MAX_LEN    = MAX_LEN_DEF,
    parameter int   LEN_W      = 5,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [REP_W-1:0]   pat_rep,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output state_e             dbg_state
`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
    ,
    output logic               y_exp
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Bit-select width for the pattern register; idx itself needs one more
    // value (MAX_LEN) to mark "all bits sent".
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // The gap counter counts down to 0; the cycle spent in GAP with a
    // count of 0 is the last idle cycle.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [REP_W-1:0]   rep_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic               len_ok;

    assign len_ok    = (pat_len != '0) && (32'(pat_len) <= MAX_LEN);
    assign pat_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state_e'(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            rep_q   <= '0;
            gap_cnt <= '0;
            x       <= IDLE_LEVEL;
            x_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // pat_ready is 1 here, so pat_valid alone is a handshake.
                    if (pat_valid) begin
                        if (len_ok) begin
                            pat_q   <= pat_data;
                            len_q   <= pat_len;
                            rep_q   <= pat_rep;
                            x       <= pat_data[0];
                            x_valid <= 1'b1;
                            idx     <= LEN_W'(1);
                            state   <= ST_SHIFT;
                        end else begin
                            // Illegal length: consume and drop, x untouched.
                            err <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (idx < len_q) begin
                        x   <= pat_q[idx[IDX_W-1:0]];
                        idx <= idx + 1'b1;
                    end else if (rep_q != '0) begin
                        rep_q <= rep_q - 1'b1;
                        if (GAP_CYCLES == 0) begin
                            // Restart immediately, no bubble between repeats.
                            x   <= pat_q[0];
                            idx <= LEN_W'(1);
                        end else begin
                            x       <= IDLE_LEVEL;
                            x_valid <= 1'b0;
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end else begin
                        x       <= IDLE_LEVEL;
                        x_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        x       <= pat_q[0];
                        x_valid <= 1'b1;
                        idx     <= LEN_W'(1);
                        state   <= ST_SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    x       <= IDLE_LEVEL;
                    x_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
    seq_expect_model u_expect (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .x_valid (x_valid),
        .y_exp   (y_exp)
    );
`endif

endmodule

// File: tb/tb_seq_pattern_generator.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_generator
//   Two generator instances: lane 0 (GAP_CYCLES=0, IDLE_LEVEL=0) and lane 1
//   (GAP_CYCLES=2, IDLE_LEVEL=1). Each lane has a transaction-level model
//   that expands every accepted offer into the list of per-cycle outputs it
//   must produce; a compare process checks every cycle against it. Directed
//   cases pin the model with literal streams; random offers follow.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_pattern_generator;
    import seq_pkg::*;

    localparam int ML    = 16;
    localparam int ENT_W = 8;

    typedef struct packed {
        logic       x;
        logic       v;
        logic       dn;
        logic       er;
        logic       bz;
        logic       rd;
        logic [1:0] st;
    } ent_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]    pv;
    logic [ML-1:0] pd   [2];
    logic [4:0]    plen [2];
    logic [3:0]    prep [2];
    logic [1:0]    rdy, xo, xv, bz, dn, er;
    logic [3:0]    dbg;
`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
    logic [1:0]    ye;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic ent_t mk(input logic x, input logic v, input logic dn_i, input logic er_i,
                                input logic bz_i, input logic rd_i, input logic [1:0] st);
        ent_t e;
        e.x = x; e.v = v; e.dn = dn_i; e.er = er_i; e.bz = bz_i; e.rd = rd_i; e.st = st;
        return e;
    endfunction

    // ---------------- lanes: DUT + model + compare ----------------
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int   GAPC = 2 * g;
        localparam logic IDL  = (g == 1);

        seq_pattern_generator #(
            .MAX_LEN    (ML),
            .LEN_W      (5),
            .GAP_CYCLES (GAPC),
            .IDLE_LEVEL (IDL)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .pat_valid (pv[g]),
            .pat_ready (rdy[g]),
            .pat_data  (pd[g]),
            .pat_len   (plen[g]),
            .pat_rep   (prep[g]),
            .x         (xo[g]),
            .x_valid   (xv[g]),
            .busy      (bz[g]),
            .done      (dn[g]),
            .err       (er[g]),
            .dbg_state (dbg[2*g +: 2])
`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
            ,
            .y_exp     (ye[g])
`endif
        );

        logic [ENT_W-1:0] exp_q[$];
        ent_t cur;
        logic prev_ok, prev_bit, y_m;

        initial begin
            cur      = mk(IDL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            prev_ok  = 1'b0;
            prev_bit = 1'b0;
            y_m      = 1'b0;
        end

        // Model: an accepted offer becomes the whole list of cycles it owns.
        always @(posedge clk or posedge rst) begin : model
            int len;
            int rep;
            logic [ML-1:0] d;
            if (rst) begin
                exp_q.delete();
                cur      = mk(IDL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
                prev_ok  = 1'b0;
                prev_bit = 1'b0;
                y_m      = 1'b0;
            end else begin
                y_m      = cur.v && prev_ok && (cur.x != prev_bit);
                prev_ok  = cur.v;
                prev_bit = cur.x;
                if (pv[g] && cur.rd) begin
                    len = int'(plen[g]);
                    rep = int'(prep[g]);
                    d   = pd[g];
                    if (len == 0 || len > ML) begin
                        exp_q.push_back(mk(IDL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0));
                    end else begin
                        for (int r = 0; r <= rep; r++) begin
                            for (int i = 0; i < len; i++)
                                exp_q.push_back(mk(d[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
                            if (r < rep)
                                for (int k = 0; k < GAPC; k++)
                                    exp_q.push_back(mk(IDL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
                        end
                        exp_q.push_back(mk(IDL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
                    end
                end
                if (exp_q.size() > 0) cur = ent_t'(exp_q.pop_front());
                else                  cur = mk(IDL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            end
        end

        always @(negedge clk) begin
            if (rst === 1'b0) begin
                chk($sformatf("lane%0d x", g),         32'(xo[g]),          32'(cur.x));
                chk($sformatf("lane%0d x_valid", g),   32'(xv[g]),          32'(cur.v));
                chk($sformatf("lane%0d done", g),      32'(dn[g]),          32'(cur.dn));
                chk($sformatf("lane%0d err", g),       32'(er[g]),          32'(cur.er));
                chk($sformatf("lane%0d busy", g),      32'(bz[g]),          32'(cur.bz));
                chk($sformatf("lane%0d pat_ready", g), 32'(rdy[g]),         32'(cur.rd));
                chk($sformatf("lane%0d state", g),     32'(dbg[2*g +: 2]),  32'(cur.st));
`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
                chk($sformatf("lane%0d y_exp", g),     32'(ye[g]),          32'(y_m));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; holds the offer until pat_ready, returns at the
    // negedge of the cycle right after the accepting edge.
    task automatic offer(input int l, input logic [ML-1:0] d, input logic [4:0] ln, input logic [3:0] rp);
        pd[l]   = d;
        plen[l] = ln;
        prep[l] = rp;
        pv[l]   = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (rdy[l]) begin
                @(negedge clk);
                pv[l] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk($sformatf("lane%0d offer timeout", l), 32'd1, 32'd0);
        pv[l] = 1'b0;
    endtask

    task automatic see(input int l, input string nm, input logic ex_x, input logic ex_v, input logic ex_dn);
        chk({nm, " x"},       32'(xo[l]), 32'(ex_x));
        chk({nm, " x_valid"}, 32'(xv[l]), 32'(ex_v));
        chk({nm, " done"},    32'(dn[l]), 32'(ex_dn));
        @(negedge clk);
    endtask

    task automatic wait_idle(input int l);
        int c;
        c = 0;
        while (bz[l] && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("lane%0d drain", l), 32'(bz[l]), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_lane(input int l, input int n);
        int pick;
        logic [4:0] ln;
        logic [3:0] rp;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pick = $urandom_range(0, 9);
            if (pick == 0)
                ln = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
            else
                ln = 5'($urandom_range(1, 16));
            rp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            offer(l, ML'($urandom), ln, rp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (checks %0d, failures %0d)", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [8:0] seq9;
        pv = 2'b00;
        for (int l = 0; l < 2; l++) begin
            pd[l] = '0; plen[l] = '0; prep[l] = '0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset state, sampled while reset is held.
        @(negedge clk);
        chk("reset lane0 x", 32'(xo[0]), 32'd0);
        chk("reset lane1 x", 32'(xo[1]), 32'd1);
        chk("reset x_valid", 32'(xv),    32'd0);
        chk("reset busy",    32'(bz),    32'd0);
        chk("reset ready",   32'(rdy),   32'd3);
        chk("reset done",    32'(dn),    32'd0);
        chk("reset err",     32'(er),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // 4-bit pattern 0110, single shot.
        offer(0, 16'b0110, 5'd4, 4'd0);
        see(0, "t1 bit0", 1'b0, 1'b1, 1'b0);
        see(0, "t1 bit1", 1'b1, 1'b1, 1'b0);
        see(0, "t1 bit2", 1'b1, 1'b1, 1'b0);
        see(0, "t1 bit3", 1'b0, 1'b1, 1'b0);
        see(0, "t1 done", 1'b0, 1'b0, 1'b1);
        see(0, "t1 after", 1'b0, 1'b0, 1'b0);

        // 101 repeated three times, no bubble.
        offer(0, 16'b101, 5'd3, 4'd2);
        seq9 = 9'b101101101;
        for (int i = 0; i < 9; i++) see(0, $sformatf("t2 bit%0d", i), seq9[i], 1'b1, 1'b0);
        see(0, "t2 done", 1'b0, 1'b0, 1'b1);
        see(0, "t2 after", 1'b0, 1'b0, 1'b0);

        // Gap lane: 10 twice with two idle cycles (idle level 1).
        offer(1, 16'b10, 5'd2, 4'd1);
        see(1, "t3 r0b0", 1'b0, 1'b1, 1'b0);
        see(1, "t3 r0b1", 1'b1, 1'b1, 1'b0);
        see(1, "t3 gap0", 1'b1, 1'b0, 1'b0);
        see(1, "t3 gap1", 1'b1, 1'b0, 1'b0);
        see(1, "t3 r1b0", 1'b0, 1'b1, 1'b0);
        see(1, "t3 r1b1", 1'b1, 1'b1, 1'b0);
        see(1, "t3 done", 1'b1, 1'b0, 1'b1);
        see(1, "t3 after", 1'b1, 1'b0, 1'b0);

        // Illegal lengths 0 and 17.
        offer(0, 16'hABCD, 5'd0, 4'd1);
        chk("t4 len0 err", 32'(er[0]), 32'd1);
        chk("t4 len0 busy", 32'(bz[0]), 32'd0);
        see(0, "t4 len0", 1'b0, 1'b0, 1'b0);
        chk("t4 len0 err clear", 32'(er[0]), 32'd0);
        offer(0, 16'hABCD, 5'd17, 4'd0);
        chk("t4 len17 err", 32'(er[0]), 32'd1);
        chk("t4 len17 busy", 32'(bz[0]), 32'd0);
        see(0, "t4 len17", 1'b0, 1'b0, 1'b0);
        chk("t4 len17 err clear", 32'(er[0]), 32'd0);

        // Reset while bit 5 of a 12-bit all-ones pattern is on x.
        offer(0, 16'h0FFF, 5'd12, 4'd0);
        repeat (5) @(negedge clk);
        chk("t5 bit5 before reset", 32'(xo[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5 async x",       32'(xo[0]),  32'd0);
        chk("t5 async x_valid", 32'(xv[0]),  32'd0);
        chk("t5 async busy",    32'(bz[0]),  32'd0);
        chk("t5 async ready",   32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) see(0, $sformatf("t5 post %0d", i), 1'b0, 1'b0, 1'b0);
        chk("t5 ready after", 32'(rdy[0]), 32'd1);

`ifdef SEQ_PATTERN_GENERATOR_EXPECT_EN
        // Stream 0,0,1,0,1,1: y_exp after bits 3, 4 and 5.
        begin
            logic [6:0] yv;
            yv = 7'b0111000;
            offer(0, 16'b110100, 5'd6, 4'd0);
            for (int i = 0; i < 7; i++) begin
                chk($sformatf("t6 y_exp cycle %0d", i), 32'(ye[0]), 32'(yv[i]));
                @(negedge clk);
            end
            wait_idle(0);
        end
`endif

        // Back-to-back: second offer is accepted in the done cycle.
        offer(0, 16'h1, 5'd1, 4'd2);
        offer(0, 16'h0, 5'd1, 4'd0);
        wait_idle(0);

        // Random offers on both lanes.
        fork
            rand_lane(0, 40);
            rand_lane(1, 40);
        join
        wait_idle(0);
        wait_idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
